// File: rtl/gpu_mem_pkg.sv
// Shared memory-port field widths and arbiter FSM state type.
package gpu_mem_pkg;

    localparam int ADR_W    = 15;
    localparam int SUBADR_W = 3;
    localparam int MASK_W   = 16;
    localparam int DATA_W   = 256;
    localparam int SIZE_W   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/gpu_mem_tag_fifo.sv
// In-order FIFO of requester indices for outstanding reads.
// DEPTH must be a power of two, at least 2.
module gpu_mem_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         i_clk,
    input  logic         i_nrst,
    input  logic         i_push,
    input  logic [W-1:0] i_tag,
    input  logic         i_pop,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_head
);

    localparam int PW = $clog2(DEPTH);

    // Extra pointer bit tells full from empty when the indices match.
    logic [PW:0]  wr_q, rd_q;
    logic [W-1:0] mem_q [DEPTH];
    logic         push_ok, pop_ok;

    assign o_empty = (wr_q == rd_q);
    assign o_full  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign o_head  = mem_q[rd_q[PW-1:0]];
    assign pop_ok  = i_pop & ~o_empty;
    // A push into a full FIFO is only allowed when the head leaves the same cycle.
    assign push_ok = i_push & (~o_full | pop_ok);

    // Pointer update; pops on an empty FIFO are ignored.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop_ok)  rd_q <= rd_q + 1'b1;
        end
    end

    // Tag storage; contents are meaningless while empty so no reset.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wr_q[PW-1:0]] <= i_tag;
    end

endmodule

// File: rtl/gpu_mem_arbiter.sv
// Arbitrates NUM_REQ requesters onto one memory command port and routes
// read data back in order via a tag FIFO.
// Define GPU_MEM_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module gpu_mem_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int TAG_DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_nrst,
    input  logic [NUM_REQ-1:0]           i_reqCommand,
    input  logic [SIZE_W*NUM_REQ-1:0]    i_reqCommandSize,
    input  logic [NUM_REQ-1:0]           i_reqWrite,
    input  logic [ADR_W*NUM_REQ-1:0]     i_reqAdr,
    input  logic [SUBADR_W*NUM_REQ-1:0]  i_reqSubadr,
    input  logic [MASK_W*NUM_REQ-1:0]    i_reqWriteMask,
    input  logic [DATA_W*NUM_REQ-1:0]    i_reqDataOut,
    output logic [NUM_REQ-1:0]           o_reqBusy,
    output logic [NUM_REQ-1:0]           o_reqDataInValid,
    output logic [DATA_W-1:0]            o_dataIn,
    output logic                         o_command,
    output logic [SIZE_W-1:0]            o_commandSize,
    output logic                         o_write,
    output logic [ADR_W-1:0]             o_adr,
    output logic [SUBADR_W-1:0]          o_subadr,
    output logic [MASK_W-1:0]            o_writeMask,
    output logic [DATA_W-1:0]            o_dataOut,
    input  logic                         i_busy,
    input  logic [DATA_W-1:0]            i_dataIn,
    input  logic                         i_dataInValid,
    output logic                         o_tagError
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e        state_q;
    logic [IDX_W-1:0]  grant_q, winner, sel;
    logic [NUM_REQ-1:0] elig;
    logic              any_elig, in_grant, gnt_cmd, xfer;
    logic              tag_full, tag_empty, tag_err_q;
    logic [IDX_W-1:0]  tag_head;

    // Reads need a free tag slot; writes never wait on the FIFO.
    assign elig = i_reqCommand & (i_reqWrite | {NUM_REQ{~tag_full}});

`ifdef GPU_MEM_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_q;

    // First eligible requester after the last one granted, wrapping.
    always_comb begin
        int idx;
        winner   = '0;
        any_elig = 1'b0;
        idx      = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(rr_q) + i) % NUM_REQ;
            if (!any_elig && elig[idx]) begin
                any_elig = 1'b1;
                winner   = IDX_W'(idx);
            end
        end
    end
`else
    // Lowest eligible index wins.
    always_comb begin
        winner   = '0;
        any_elig = |elig;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (elig[i]) winner = IDX_W'(i);
        end
    end
`endif

    assign in_grant = (state_q == ST_GRANT);
    assign gnt_cmd  = i_reqCommand[grant_q];
    assign xfer     = in_grant & gnt_cmd & ~i_busy;
    assign sel      = in_grant ? grant_q : '0;

    assign o_command     = in_grant & gnt_cmd;
    assign o_commandSize = i_reqCommandSize[int'(sel)*SIZE_W +: SIZE_W];
    assign o_write       = i_reqWrite[sel];
    assign o_adr         = i_reqAdr[int'(sel)*ADR_W +: ADR_W];
    assign o_subadr      = i_reqSubadr[int'(sel)*SUBADR_W +: SUBADR_W];
    assign o_writeMask   = i_reqWriteMask[int'(sel)*MASK_W +: MASK_W];
    assign o_dataOut     = i_reqDataOut[int'(sel)*DATA_W +: DATA_W];
    assign o_dataIn      = i_dataIn;
    assign o_tagError    = tag_err_q;

    // Only the granted requester sees busy low, and only while memory accepts.
    always_comb begin
        o_reqBusy = '1;
        if (in_grant && !i_busy) o_reqBusy[grant_q] = 1'b0;
    end

    // Read-data strobe goes to the oldest outstanding read.
    always_comb begin
        o_reqDataInValid = '0;
        if (i_dataInValid && !tag_empty) o_reqDataInValid[tag_head] = 1'b1;
    end

    gpu_mem_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .W     (IDX_W)
    ) u_tag_fifo (
        .i_clk   (i_clk),
        .i_nrst  (i_nrst),
        .i_push  (xfer & ~i_reqWrite[grant_q]),
        .i_tag   (grant_q),
        .i_pop   (i_dataInValid),
        .o_full  (tag_full),
        .o_empty (tag_empty),
        .o_head  (tag_head)
    );

    // Sticky flag for read data that arrives with nothing outstanding.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst)                       tag_err_q <= 1'b0;
        else if (i_dataInValid && tag_empty) tag_err_q <= 1'b1;
    end

    // Grant FSM: one command per grant, abandon if the requester withdraws.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
`ifdef GPU_MEM_ARB_ROUND_ROBIN_EN
            rr_q    <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_elig) begin
                        state_q <= ST_GRANT;
                        grant_q <= winner;
`ifdef GPU_MEM_ARB_ROUND_ROBIN_EN
                        rr_q    <= winner;
`endif
                    end
                end
                ST_GRANT: begin
                    if (!gnt_cmd || !i_busy) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// Randomized bench for gpu_mem_arbiter against a transaction-level model:
// the model tracks "who holds the port" as an integer and outstanding reads
// as a queue of requester numbers.
module tb_gpu_mem_arbiter;
    import gpu_mem_pkg::*;

    localparam int N  = 4;
    localparam int TD = 4;

    logic                   clk = 1'b0;
    logic                   nrst;
    logic [N-1:0]           cmd, wr;
    logic [SIZE_W*N-1:0]    csz;
    logic [ADR_W*N-1:0]     adr;
    logic [SUBADR_W*N-1:0]  sub;
    logic [MASK_W*N-1:0]    msk;
    logic [DATA_W*N-1:0]    dout;
    logic                   busy, div;
    logic [DATA_W-1:0]      din;

    logic [N-1:0]           reqBusy, reqDv;
    logic [DATA_W-1:0]      dataIn, dataOut;
    logic                   command, write, tagErr;
    logic [SIZE_W-1:0]      commandSize;
    logic [ADR_W-1:0]       oadr;
    logic [SUBADR_W-1:0]    osub;
    logic [MASK_W-1:0]      omsk;

    gpu_mem_arbiter #(.NUM_REQ(N), .TAG_DEPTH(TD)) dut (
        .i_clk            (clk),
        .i_nrst           (nrst),
        .i_reqCommand     (cmd),
        .i_reqCommandSize (csz),
        .i_reqWrite       (wr),
        .i_reqAdr         (adr),
        .i_reqSubadr      (sub),
        .i_reqWriteMask   (msk),
        .i_reqDataOut     (dout),
        .o_reqBusy        (reqBusy),
        .o_reqDataInValid (reqDv),
        .o_dataIn         (dataIn),
        .o_command        (command),
        .o_commandSize    (commandSize),
        .o_write          (write),
        .o_adr            (oadr),
        .o_subadr         (osub),
        .o_writeMask      (omsk),
        .o_dataOut        (dataOut),
        .i_busy           (busy),
        .i_dataIn         (din),
        .i_dataInValid    (div),
        .o_tagError       (tagErr)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model state: holder of the port (-1 = none), last winner, read tags.
    int gnt;
    int last;
    int tags[$];
    bit terr;
    int took;

    function automatic void model_reset();
        gnt  = -1;
        last = 0;
        tags.delete();
        terr = 1'b0;
    endfunction

    function automatic int pick(input logic [N-1:0] e);
        int w;
        w = -1;
`ifdef GPU_MEM_ARB_ROUND_ROBIN_EN
        for (int i = 1; i <= N; i++)
            if (w < 0 && e[(last + i) % N]) w = (last + i) % N;
`else
        for (int i = 0; i < N; i++)
            if (w < 0 && e[i]) w = i;
`endif
        return w;
    endfunction

    // Check outputs mid-cycle, then advance the model across the next edge.
    task automatic cycle();
        logic [N-1:0] eb, edv, el;
        int sz0, s;
        #4;
        s   = (gnt >= 0) ? gnt : 0;
        eb  = '1;
        if (gnt >= 0 && !busy) eb[gnt] = 1'b0;
        edv = '0;
        if (div && tags.size() > 0) edv[tags[0]] = 1'b1;
        chk("command", 256'(command), 256'((gnt >= 0) && cmd[s]));
        chk("reqBusy", 256'(reqBusy), 256'(eb));
        chk("reqDv",   256'(reqDv),   256'(edv));
        chk("tagErr",  256'(tagErr),  256'(terr));
        chk("dataIn",  dataIn, din);
        chk("adr",     256'(oadr),    256'(adr[s*ADR_W +: ADR_W]));
        chk("write",   256'(write),   256'(wr[s]));
        chk("dataOut", dataOut, dout[s*DATA_W +: DATA_W]);
        took = -1;
        if (!nrst) begin
            model_reset();
        end else begin
            sz0 = tags.size();
            if (div) begin
                if (sz0 > 0) void'(tags.pop_front());
                else terr = 1'b1;
            end
            if (gnt < 0) begin
                for (int k = 0; k < N; k++) el[k] = cmd[k] && (wr[k] || sz0 < TD);
                gnt = pick(el);
                if (gnt >= 0) last = gnt;
            end else if (!cmd[gnt]) begin
                gnt = -1;
            end else if (!busy) begin
                took = gnt;
                if (!wr[gnt]) tags.push_back(gnt);
                gnt = -1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic new_req(input int k, input int wmode);
        cmd[k] = 1'b1;
        wr[k]  = (wmode < 0) ? 1'($urandom_range(0, 1)) : 1'(wmode);
        csz[k*SIZE_W +: SIZE_W]     = SIZE_W'($urandom);
        adr[k*ADR_W +: ADR_W]       = ADR_W'($urandom);
        sub[k*SUBADR_W +: SUBADR_W] = SUBADR_W'($urandom);
        msk[k*MASK_W +: MASK_W]     = MASK_W'($urandom);
        for (int j = 0; j < 8; j++) dout[k*DATA_W + j*32 +: 32] = $urandom;
    endtask

    task automatic run_rand(input int n, input int ret_pct, input int busy_pct);
        for (int c = 0; c < n; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!cmd[k] && $urandom_range(0, 99) < 30) new_req(k, -1);
                else if (cmd[k] && $urandom_range(0, 99) < 3) cmd[k] = 1'b0;
            end
            busy = ($urandom_range(0, 99) < busy_pct);
            div  = (tags.size() > 0) && ($urandom_range(0, 99) < ret_pct);
            for (int j = 0; j < 8; j++) din[j*32 +: 32] = $urandom;
            cycle();
            if (took >= 0) cmd[took] = 1'b0;
        end
    endtask

    task automatic reset_mid_grant();
        int guard;
        guard = 0;
        while (gnt < 0 && guard < 50) begin
            if (!cmd[1]) new_req(1, -1);
            busy = 1'b1;
            div  = 1'b0;
            cycle();
            guard++;
        end
        chk("rst_grant_reached", 256'(gnt >= 0), 256'(1));
        nrst = 1'b0;
        #1;
        chk("rst_cmd_now", 256'(command), 256'(0));
        chk("rst_busy_now", 256'(reqBusy), 256'({N{1'b1}}));
        model_reset();
        div = 1'b1;
        repeat (2) cycle();
        div  = 1'b0;
        nrst = 1'b1;
    endtask

    initial begin
        nrst = 1'b0;
        cmd = '0; wr = '0; csz = '0; adr = '0; sub = '0; msk = '0; dout = '0;
        busy = 1'b0; div = 1'b0; din = '0;
        model_reset();
        took = -1;
        #2;
        chk("reset_cmd",   256'(command), 256'(0));
        chk("reset_busy",  256'(reqBusy), 256'({N{1'b1}}));
        chk("reset_dv",    256'(reqDv),   256'(0));
        chk("reset_tagerr", 256'(tagErr), 256'(0));
        @(posedge clk);
        #1;
        cycle();
        nrst = 1'b1;

        // Single read on requester 1, data returned five cycles after it.
        new_req(1, 0);
        cycle();
        cycle();
        if (took >= 0) cmd[took] = 1'b0;
        repeat (4) cycle();
        div = 1'b1;
        din = {8{32'hA5A5_0001}};
        #4;
        chk("single_read_dv", 256'(reqDv), 256'(4'b0010));
        cycle();
        div = 1'b0;

        // Two writers held high: winner order comes from the model.
        for (int c = 0; c < 16; c++) begin
            if (!cmd[0]) new_req(0, 1);
            if (!cmd[2]) new_req(2, 1);
            cycle();
            if (took >= 0) cmd[took] = 1'b0;
        end
        cmd = '0;

        // Backpressure: hold busy for three GRANT cycles.
        new_req(3, 1);
        busy = 1'b1;
        repeat (4) cycle();
        busy = 1'b0;
        cycle();
        if (took >= 0) cmd[took] = 1'b0;
        cycle();

        // Fill the tag FIFO, then a pending read versus a write on req3.
        for (int c = 0; c < 20 && tags.size() < TD; c++) begin
            if (!cmd[0]) new_req(0, 0);
            cycle();
            if (took >= 0) cmd[took] = 1'b0;
        end
        chk("tags_full", 256'(tags.size()), 256'(TD));
        new_req(0, 0);
        new_req(3, 1);
        repeat (4) cycle();
        if (took >= 0) cmd[took] = 1'b0;
        div = 1'b1;
        cycle();
        div = 1'b0;
        repeat (4) begin
            cycle();
            if (took >= 0) cmd[took] = 1'b0;
        end

        run_rand(600, 50, 25);
        run_rand(600, 10, 10);
        run_rand(400, 80, 40);

        // Drain, then deliver data with nothing outstanding.
        cmd = '0;
        for (int c = 0; c < 40 && (tags.size() > 0 || gnt >= 0); c++) begin
            div = (tags.size() > 0);
            cycle();
        end
        chk("drained", 256'(tags.size()), 256'(0));
        div = 1'b1;
        cycle();
        div = 1'b0;
        repeat (3) cycle();

        reset_mid_grant();
        run_rand(600, 40, 30);
        reset_mid_grant();
        repeat (2) cycle();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/gpu_mem_arbiter.md
GPU_MEM_ARBITER -- requirements
Module: gpu_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the VRAM/DDR command port (2..8).
REQ-002 SHALL have parameter TAG_DEPTH, default 4, maximum number of outstanding reads, power of two.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port i_nrst, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port i_reqCommand, input, NUM_REQ, per-requester command request.
REQ-006 SHALL have port i_reqCommandSize, input, 2*NUM_REQ, per-requester command size.
REQ-007 SHALL have port i_reqWrite, input, NUM_REQ, per-requester write (1) or read (0).
REQ-008 SHALL have port i_reqAdr, input, 15*NUM_REQ, per-requester address.
REQ-009 SHALL have port i_reqSubadr, input, 3*NUM_REQ, per-requester sub-address.
REQ-010 SHALL have port i_reqWriteMask, input, 16*NUM_REQ, per-requester write mask.
REQ-011 SHALL have port i_reqDataOut, input, 256*NUM_REQ, per-requester write data.
REQ-012 SHALL have port o_reqBusy, output, NUM_REQ, per-requester busy; the command is taken on the cycle this bit is 0.
REQ-013 SHALL have port o_reqDataInValid, output, NUM_REQ, per-requester read-data strobe.
REQ-014 SHALL have port o_dataIn, output, 256, read data broadcast to all requesters.
REQ-015 SHALL have ports o_command, o_commandSize[1:0], o_write, o_adr[14:0], o_subadr[2:0], o_writeMask[15:0], o_dataOut[255:0] as outputs toward memory.
REQ-016 SHALL have ports i_busy, i_dataIn[255:0], i_dataInValid as inputs from memory.
REQ-017 SHALL have port o_tagError, output, 1, sticky flag set when read data arrives with no read outstanding.

Function
REQ-018 SHALL use a two-state FSM: IDLE and GRANT.
REQ-019 In IDLE, when any eligible i_reqCommand bit is set, SHALL register the winner index and enter GRANT on the next edge; the request-to-o_command latency is 1 cycle.
REQ-020 A requester SHALL be eligible only if it requests a write, or it requests a read and the tag FIFO is not full.
REQ-021 In GRANT, SHALL drive all memory command outputs from the granted requester, with o_command = i_reqCommand[grant].
REQ-022 A transfer SHALL occur on a cycle with o_command=1 and i_busy=0.
REQ-023 o_reqBusy[k] SHALL be 0 only when state=GRANT, grant=k and i_busy=0; all other bits SHALL be 1.
REQ-024 After a transfer, SHALL return to IDLE, so each grant covers exactly one command.
REQ-025 If the granted requester drops i_reqCommand while in GRANT, SHALL return to IDLE with no transfer.
REQ-026 On each read transfer, SHALL push the grant index into an in-order tag FIFO.
REQ-027 On each i_dataInValid, SHALL pop the tag FIFO and pulse o_reqDataInValid[head] for that cycle; o_dataIn = i_dataIn combinationally.
REQ-028 A push and a pop in the same cycle SHALL both take effect, leaving the occupancy unchanged.
REQ-029 If i_dataInValid arrives with the FIFO empty, SHALL assert no strobe, set o_tagError, and keep the pointers unchanged.
REQ-030 Outside GRANT, o_command SHALL be 0 and the other command outputs SHALL be don't-care (driven from requester 0).

Reset
REQ-031 On i_nrst low, state SHALL be IDLE, grant and round-robin pointer SHALL be 0, the FIFO SHALL be empty, and o_tagError SHALL be 0.
REQ-032 During reset, o_command and o_reqDataInValid SHALL be 0 and o_reqBusy SHALL be all ones.
REQ-033 A reset during GRANT or with reads outstanding SHALL discard all pending tags.

Configuration
REQ-034 With macro GPU_MEM_ARB_ROUND_ROBIN_EN defined, the winner SHALL be the first eligible requester after the last granted index, wrapping modulo NUM_REQ.
REQ-035 Without GPU_MEM_ARB_ROUND_ROBIN_EN, the winner SHALL be the lowest eligible index (fixed priority), and the pointer register SHALL be absent.

Structure
REQ-036 Package gpu_mem_pkg SHALL hold the memory field widths (ADR_W=15, SUBADR_W=3, MASK_W=16, DATA_W=256, SIZE_W=2) and the FSM state typedef.
REQ-037 The tag FIFO SHALL be a sub-module, gpu_mem_tag_fifo, with push, pop, full, empty and head outputs.

Verification
REQ-038 Single requester: req1 read with i_busy=0 -> o_command high on cycle +1; data returned 5 cycles later -> o_reqDataInValid=4'b0010.
REQ-039 Contention with RR enabled: req0 and req2 both held high -> grants alternate 0,2,0,2; with RR disabled -> req0 always wins.
REQ-040 Backpressure: i_busy=1 for 3 cycles in GRANT -> o_command held with stable address; transfer on the cycle i_busy falls.
REQ-041 Tag full (TAG_DEPTH=4): 4 reads with no return -> 5th read not granted while a pending write on req3 is granted; first data return -> read granted.
REQ-042 Simultaneous push and pop: read transfer on the same cycle as i_dataInValid -> occupancy unchanged and strobe routed to the oldest tag.
REQ-043 Spurious data: i_dataInValid with no reads outstanding -> no strobe, o_tagError=1 until reset; reset asserted mid-GRANT -> o_command=0 immediately.
